// File: rtl/rd_fifo_refill_ctrl.sv
// rd_fifo_refill_ctrl: read-side refill scheduler for the frame-buffer read path.
// Issues DDR read bursts for one frame, throttled by a credit count of free FIFO words,
// forwards returned beats as FIFO write enables and flushes the FIFO on a mid-frame restart.
// Optional statistics outputs (burst_cnt, credit_err) exist when RD_REFILL_STAT_EN is defined.
module rd_fifo_refill_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 28,
  parameter int unsigned BURST_LEN   = 64,
  parameter int unsigned FRAME_BEATS = 115200,
  parameter int unsigned FIFO_WORDS  = 1024,
  parameter int unsigned FLUSH_CYC   = 8,
  localparam int unsigned LEN_W      = $clog2(BURST_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic [ADDR_WIDTH-1:0] frame_base,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [LEN_W-1:0]      rd_len,
  input  logic                  rd_ack,
  input  logic                  rd_beat,
  output logic                  fifo_wr_en,
  output logic                  fifo_flush,
  input  logic                  credit_ret,
`ifdef RD_REFILL_STAT_EN
  output logic [15:0]           burst_cnt,
  output logic                  credit_err,
`endif
  output logic                  frame_busy
);

  localparam int unsigned CRED_W  = $clog2(FIFO_WORDS + 1);
  localparam int unsigned CW1     = CRED_W + 1;
  localparam int unsigned BEATS_W = $clog2(FRAME_BEATS + 1);
  localparam int unsigned FLUSH_W = $clog2(FLUSH_CYC + 1);

  localparam logic [CRED_W-1:0]  CredFull   = CRED_W'(FIFO_WORDS);
  localparam logic [BEATS_W-1:0] BeatsFull  = BEATS_W'(FRAME_BEATS);
  localparam logic [FLUSH_W-1:0] FlushLast  = FLUSH_W'(FLUSH_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StReq,
    StWaitData,
    StDrain,
    StFlush
  } state_e;

  state_e               state_q;
  logic [CRED_W-1:0]    credits_q;
  logic [CRED_W-1:0]    credits_d;
  logic [BEATS_W-1:0]   beats_left_q;
  logic [LEN_W-1:0]     beat_cnt_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [FLUSH_W-1:0]   flush_cnt_q;
  logic [LEN_W-1:0]     len_c;
  logic                 cred_ok;
  logic                 acked;
  logic [CW1-1:0]       cred_sum;

  assign acked      = (state_q == StReq) && rd_ack;
  assign fifo_wr_en = rd_beat && (state_q == StWaitData);
  assign frame_busy = (state_q != StIdle);

  // Next burst length is the smaller of a full burst and what is left of the frame.
  always_comb begin
    if (32'(beats_left_q) >= BURST_LEN) len_c = LEN_W'(BURST_LEN);
    else                                len_c = LEN_W'(beats_left_q);
    cred_ok = (32'(credits_q) >= 32'(len_c));
  end

  // Credit update: returns and burst debits net out in the same cycle; FLUSH reloads.
  always_comb begin
    cred_sum = CW1'(credits_q);
    if (credit_ret) cred_sum = cred_sum + CW1'(1);
    if (acked)      cred_sum = cred_sum - CW1'(rd_len);
    if ((state_q == StFlush) || (cred_sum > CW1'(FIFO_WORDS))) credits_d = CredFull;
    else                                                       credits_d = cred_sum[CRED_W-1:0];
  end

  // Refill FSM with registered request/flush outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rd_req       <= 1'b0;
      rd_addr      <= '0;
      rd_len       <= '0;
      fifo_flush   <= 1'b0;
      credits_q    <= CredFull;
      beats_left_q <= '0;
      beat_cnt_q   <= '0;
      base_q       <= '0;
      flush_cnt_q  <= '0;
    end else begin
      credits_q <= credits_d;
      if (frame_start) base_q <= frame_base;
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            rd_addr      <= frame_base;
            beats_left_q <= BeatsFull;
            state_q      <= StCheck;
          end
        end
        StCheck: begin
          // A restart here has no burst outstanding, but the FIFO may hold stale data.
          if (frame_start) begin
            fifo_flush  <= 1'b1;
            flush_cnt_q <= FlushLast;
            state_q     <= StFlush;
          end else if (beats_left_q == '0) begin
            state_q <= StIdle;
          end else if (cred_ok) begin
            rd_req  <= 1'b1;
            rd_len  <= len_c;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (rd_ack) begin
            rd_req       <= 1'b0;
            rd_addr      <= rd_addr + ADDR_WIDTH'(rd_len);
            beats_left_q <= beats_left_q - BEATS_W'(rd_len);
            beat_cnt_q   <= rd_len;
            state_q      <= frame_start ? StDrain : StWaitData;
          end else if (frame_start) begin
            rd_req      <= 1'b0;
            fifo_flush  <= 1'b1;
            flush_cnt_q <= FlushLast;
            state_q     <= StFlush;
          end
        end
        StWaitData: begin
          if (rd_beat) beat_cnt_q <= beat_cnt_q - LEN_W'(1);
          if (frame_start) begin
            state_q <= StDrain;
          end else if (rd_beat && (beat_cnt_q == LEN_W'(1))) begin
            state_q <= StCheck;
          end
        end
        StDrain: begin
          // Beats of the aborted burst must still arrive before the FIFO is reset.
          if ((beat_cnt_q == '0) || (rd_beat && (beat_cnt_q == LEN_W'(1)))) begin
            beat_cnt_q  <= '0;
            fifo_flush  <= 1'b1;
            flush_cnt_q <= FlushLast;
            state_q     <= StFlush;
          end else if (rd_beat) begin
            beat_cnt_q <= beat_cnt_q - LEN_W'(1);
          end
        end
        StFlush: begin
          if (flush_cnt_q == '0) begin
            fifo_flush   <= 1'b0;
            rd_addr      <= frame_start ? frame_base : base_q;
            beats_left_q <= BeatsFull;
            state_q      <= StCheck;
          end else begin
            flush_cnt_q <= flush_cnt_q - FLUSH_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef RD_REFILL_STAT_EN
  // Acked-burst counter (per frame) and sticky flag for a credit return at full credits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt  <= '0;
      credit_err <= 1'b0;
    end else begin
      if (frame_start) burst_cnt <= '0;
      else if (acked)  burst_cnt <= burst_cnt + 16'd1;
      if (credit_ret && (credits_q == CredFull) && (state_q != StFlush)) credit_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rd_fifo_refill_ctrl.sv
// Scoreboard bench for rd_fifo_refill_ctrl (FRAME_BEATS=200, FIFO_WORDS=128).
module tb_rd_fifo_refill_ctrl;

  localparam int unsigned AW = 28;
  localparam int unsigned BL = 64;
  localparam int unsigned FB = 200;
  localparam int unsigned FW = 128;
  localparam int unsigned FC = 8;
  localparam int unsigned LW = $clog2(BL) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic [AW-1:0] frame_base = '0;
  logic          rd_ack = 1'b0;
  logic          rd_beat = 1'b0;
  logic          credit_ret = 1'b0;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [LW-1:0] rd_len;
  logic          fifo_wr_en;
  logic          fifo_flush;
  logic          frame_busy;
`ifdef RD_REFILL_STAT_EN
  logic [15:0]   burst_cnt;
  logic          credit_err;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } req_t;

  req_t exp_req[$];
  int   exp_flush[$];
  int   checks = 0;
  int   failures = 0;
  int   wr_cnt = 0;
  int   w0;

  rd_fifo_refill_ctrl #(
    .ADDR_WIDTH (AW),
    .BURST_LEN  (BL),
    .FRAME_BEATS(FB),
    .FIFO_WORDS (FW),
    .FLUSH_CYC  (FC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .frame_base (frame_base),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_len     (rd_len),
    .rd_ack     (rd_ack),
    .rd_beat    (rd_beat),
    .fifo_wr_en (fifo_wr_en),
    .fifo_flush (fifo_flush),
    .credit_ret (credit_ret),
`ifdef RD_REFILL_STAT_EN
    .burst_cnt  (burst_cnt),
    .credit_err (credit_err),
`endif
    .frame_busy (frame_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [AW-1:0] a, input int l);
    req_t r;
    r.addr = a;
    r.len  = LW'(l);
    exp_req.push_back(r);
  endtask

  task automatic pulse_start(input logic [AW-1:0] base);
    frame_base  = base;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  // Cycles from now until rd_req is seen, bounded.
  task automatic wait_req(input string name, input int exp_lat);
    int n;
    n = 0;
    while (!rd_req && n < 300) begin
      cyc();
      n++;
    end
    if (!rd_req) begin
      checks++;
      failures++;
      $display("FAIL %s: no rd_req within 300 cycles, expected after %0d", name, exp_lat);
    end else begin
      check(name, 64'(n), 64'(exp_lat));
    end
  endtask

  task automatic ack(input int delay);
    repeat (delay) cyc();
    rd_ack = 1'b1;
    cyc();
    rd_ack = 1'b0;
  endtask

  task automatic send_beats(input int n);
    for (int i = 0; i < n; i++) begin
      rd_beat = 1'b1;
      cyc();
    end
    rd_beat = 1'b0;
  endtask

  task automatic give_credits(input int n);
    for (int i = 0; i < n; i++) begin
      credit_ret = 1'b1;
      cyc();
    end
    credit_ret = 1'b0;
  endtask

  // Monitor: accepted requests, request hold while unacked, flush pulse length, write count.
  initial begin
    logic          prev_req;
    logic          prev_ack;
    logic [AW-1:0] prev_addr;
    logic [LW-1:0] prev_len;
    int            flush_run;
    req_t          e;
    int            ef;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = '0;
    prev_len  = '0;
    flush_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req  = 1'b0;
        flush_run = 0;
      end else begin
        if (fifo_wr_en) wr_cnt++;
        if (rd_req && prev_req && !prev_ack) begin
          check("req_hold_addr", 64'(rd_addr), 64'(prev_addr));
          check("req_hold_len", 64'(rd_len), 64'(prev_len));
        end
        if (rd_req && rd_ack) begin
          if (exp_req.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_req: got addr 0x%0h len %0d, none expected", rd_addr, rd_len);
          end else begin
            e = exp_req.pop_front();
            check("req_addr", 64'(rd_addr), 64'(e.addr));
            check("req_len", 64'(rd_len), 64'(e.len));
          end
        end
        if (fifo_flush) begin
          flush_run++;
        end else if (flush_run != 0) begin
          if (exp_flush.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_flush: got %0d cycles, none expected", flush_run);
          end else begin
            ef = exp_flush.pop_front();
            check("flush_len", 64'(flush_run), 64'(ef));
          end
          flush_run = 0;
        end
        prev_req  = rd_req;
        prev_ack  = rd_ack;
        prev_addr = rd_addr;
        prev_len  = rd_len;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    check("rst_rd_req", 64'(rd_req), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_rd_len", 64'(rd_len), 64'd0);
    check("rst_fifo_flush", 64'(fifo_flush), 64'd0);
    check("rst_frame_busy", 64'(frame_busy), 64'd0);
    // Beat while idle is ignored
    rd_beat = 1'b1;
    #1;
    check("idle_beat_wr_en", 64'(fifo_wr_en), 64'd0);
    cyc();
    rd_beat = 1'b0;
    check("idle_beat_count", 64'(wr_cnt), 64'd0);

    // Frame at 0x100: two bursts exhaust 128 credits, then credit-gated refill
    exp_push(28'h100, 64);
    exp_push(28'h140, 64);
    exp_push(28'h180, 64);
    exp_push(28'h1C0, 8);
    w0 = wr_cnt;
    pulse_start(28'h100);
    check("busy_after_start", 64'(frame_busy), 64'd1);
    wait_req("lat_start", 1);
    ack(0);
    send_beats(64);
    wait_req("lat_after_beats", 1);
    ack(0);
    send_beats(64);
    check("wr_cnt_128", 64'(wr_cnt - w0), 64'd128);
    repeat (20) cyc();
    check("stall_no_credit", 64'(rd_req), 64'd0);
    give_credits(63);
    cyc();
    check("stall_63_credits", 64'(rd_req), 64'd0);
    give_credits(1);
    wait_req("lat_credit64", 1);
    ack(0);
    send_beats(64);
    give_credits(8);
    wait_req("lat_credit8", 1);
    ack(0);
    send_beats(8);
    check("busy_at_last_beat", 64'(frame_busy), 64'd1);
    cyc();
    check("busy_drop", 64'(frame_busy), 64'd0);
    check("wr_cnt_frame", 64'(wr_cnt - w0), 64'd200);
    give_credits(128);
`ifdef RD_REFILL_STAT_EN
    check("stat_burst_cnt", 64'(burst_cnt), 64'd4);
    check("stat_no_err", 64'(credit_err), 64'd0);
    give_credits(1);
    check("stat_credit_err", 64'(credit_err), 64'd1);
`endif

    // Delayed ack, then restart after 20 of 64 beats
    exp_push(28'h2000, 64);
    pulse_start(28'h2000);
    wait_req("lat_start2", 1);
    ack(10);
    w0 = wr_cnt;
    send_beats(20);
    check("wr_cnt_20", 64'(wr_cnt - w0), 64'd20);
    exp_flush.push_back(FC);
    pulse_start(28'h3000);
`ifdef RD_REFILL_STAT_EN
    check("stat_err_held", 64'(credit_err), 64'd1);
    check("stat_cnt_clear", 64'(burst_cnt), 64'd0);
`endif
    w0 = wr_cnt;
    send_beats(44);
    check("drain_no_wr", 64'(wr_cnt - w0), 64'd0);
    check("flush_active", 64'(fifo_flush), 64'd1);
    wait_req("lat_after_drain", FC + 1);
    check("restart_addr", 64'(rd_addr), 64'h3000);
    check("restart_len", 64'(rd_len), 64'd64);

    // Restart while request is pending without ack
    cyc();
    exp_flush.push_back(FC);
    pulse_start(28'h4000);
    check("req_dropped", 64'(rd_req), 64'd0);
    check("flush_active2", 64'(fifo_flush), 64'd1);
    exp_push(28'h4000, 64);
    exp_push(28'h4040, 64);
    exp_push(28'h4080, 64);
    exp_push(28'h40C0, 8);
    wait_req("lat_after_flush", FC + 1);

    // Credits 100 with a return coincident with the ack leave 37
    ack(0);
    give_credits(36);
    send_beats(64);
    wait_req("lat_c2", 1);
    credit_ret = 1'b1;
    rd_ack = 1'b1;
    cyc();
    credit_ret = 1'b0;
    rd_ack = 1'b0;
    send_beats(64);
    give_credits(26);
    cyc();
    cyc();
    check("stall_63_after_37", 64'(rd_req), 64'd0);
    give_credits(1);
    wait_req("lat_c3", 1);
    ack(0);
    send_beats(64);
    give_credits(8);
    wait_req("lat_c4", 1);
    ack(0);
    send_beats(8);
    cyc();
    check("busy_drop2", 64'(frame_busy), 64'd0);

    // Reset mid-burst restores full credits
    give_credits(64);
    exp_push(28'h5000, 64);
    pulse_start(28'h5000);
    wait_req("lat_start5", 1);
    ack(0);
    send_beats(10);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(frame_busy), 64'd0);
    check("midrst_addr", 64'(rd_addr), 64'd0);
    check("midrst_len", 64'(rd_len), 64'd0);
`ifdef RD_REFILL_STAT_EN
    check("midrst_err", 64'(credit_err), 64'd0);
`endif
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    exp_push(28'h6000, 64);
    pulse_start(28'h6000);
    wait_req("lat_after_rst", 1);
    ack(0);
    repeat (3) cyc();

    check("req_queue_empty", 64'(exp_req.size()), 64'd0);
    check("flush_queue_empty", 64'(exp_flush.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
